rr_onehot_arbiter: RTL

- Round-robin arbiter sharing one downstream resource among N requesters.
- Picks a winner and drives the grant both as a binary index and as a registered one-hot vector, the same index/one-hot pair produced by our binary-to-one-hot decoder.
- Holds each grant until the requester releases it or a hold limit expires.
- Sits between request sources and the shared resource's select/enable lines.

---
 rtl/rr_onehot_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin arbiter sharing one resource among N requesters.
// Each grant is held until its requester drops the request or MAX_HOLD cycles
// have elapsed. A new owner is picked on the same edge the old grant ends, so
// there is no idle bubble between owners.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        [N-1:0]     request vector, bit i = requester i wants the resource
//   gnt_onehot [N-1:0]     registered one-hot grant, zero when idle
//   gnt_idx    [IDX_W-1:0] registered binary grant index, zero when idle
//   gnt_valid              a grant is active
//   timeout                one-cycle pulse after a grant is force-released

// Binary-to-one-hot decoder. One comparator per output bit.
module rr_onehot_dec #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign onehot[i] = (idx == IDX_W'(i));
  end
endmodule

module rr_onehot_arbiter #(
  parameter int N        = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);
  // Counter only has to reach MAX_HOLD-1.
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [HW-1:0]    hold_cnt;

  logic [IDX_W-1:0] win, cand;
  logic [N-1:0]     win_oh;
  logic             found;
  logic             cur_req, hold_last, rearb;

  // Search upward from ptr; IDX_W-bit addition wraps modulo N since N is a
  // power of two.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  rr_onehot_dec #(.N(N), .IDX_W(IDX_W)) u_dec (
    .idx    (win),
    .onehot (win_oh)
  );

  assign cur_req   = req[gnt_idx];
  assign hold_last = (hold_cnt == HW'(MAX_HOLD - 1));
  // Arbitrate when idle, on release, or when the hold limit is reached.
  assign rearb     = (state == IDLE) || !cur_req || hold_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      gnt_onehot <= '0;
      gnt_idx    <= '0;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (rearb) begin
        // A grant still requested at this point can only be ending on the limit.
        timeout <= (state == GRANT) && cur_req;
        if (found) begin
          state      <= GRANT;
          gnt_idx    <= win;
          gnt_onehot <= win_oh;
          gnt_valid  <= 1'b1;
          hold_cnt   <= '0;
          ptr        <= win + IDX_W'(1);
        end else begin
          state      <= IDLE;
          gnt_idx    <= '0;
          gnt_onehot <= '0;
          gnt_valid  <= 1'b0;
          hold_cnt   <= '0;
        end
      end else begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end
endmodule
